// File: rtl/fetch_unit.sv
// fetch_unit: registered PC / imem request engine feeding a FWFT instruction queue with redirect flush
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     o_imem_req,
    output logic [ADDR_W-1:0]        o_imem_addr,
    input  logic                     i_imem_ack,
    input  logic [31:0]              i_imem_data,
    input  logic                     i_redirect,
    input  logic [ADDR_W-1:0]        i_redirect_addr,
    output logic                     o_inst_valid,
    output logic [31:0]              o_inst,
    output logic [ADDR_W-1:0]        o_inst_pc,
    output logic [ADDR_W-1:0]        o_inst_pc_plus4,
    input  logic                     i_inst_ready,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_next, r_drop_addr, w_target;
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count, w_count_next;
    logic              r_req, w_push, w_pop;
    logic [31:0]       r_mem_inst [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];

    // next-state, next-PC and queue occupancy; redirect overrides every other event
    always_comb begin
        w_pop           = (r_count != '0) & i_inst_ready;
        w_push          = (r_state == REQ) & i_imem_ack & ~i_redirect;
        w_count_next    = r_count + CW'(w_push) - CW'(w_pop);
        w_target        = i_redirect_addr & ~ADDR_W'(3);
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        if (i_redirect) begin
            w_fetch_pc_next = w_target;
            w_state_next    = (r_state == DROP || (r_state == REQ && !i_imem_ack)) ? DROP : REQ;
        end else begin
            case (r_state)
                IDLE: w_state_next = (r_count < CW'(DEPTH)) ? REQ : IDLE;
                REQ: begin
                    if (i_imem_ack) begin
                        w_fetch_pc_next = r_fetch_pc + ADDR_W'(4);
                        w_state_next    = (w_count_next < CW'(DEPTH)) ? REQ : IDLE;
                    end
                end
                DROP: w_state_next = i_imem_ack ? REQ : DROP;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // fetch state, PC, the address of a request made stale by redirect, and registered req
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
            r_req       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_req      <= (w_state_next != IDLE);
            if (r_state == REQ && w_state_next == DROP)
                r_drop_addr <= r_fetch_pc;
        end
    end

    // queue pointers and occupancy; redirect empties the queue
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_push);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_count <= w_count_next;
        end
    end

    // queue storage: instruction word with the address it was fetched from
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_inst[r_wptr] <= i_imem_data;
            r_mem_pc[r_wptr]   <= r_fetch_pc;
        end
    end

    assign o_imem_req      = r_req;
    assign o_imem_addr     = (r_state == DROP) ? r_drop_addr : r_fetch_pc;
    assign o_inst_valid    = (r_count != '0);
    assign o_inst          = r_mem_inst[r_rptr];
    assign o_inst_pc       = r_mem_pc[r_rptr];
    assign o_inst_pc_plus4 = r_mem_pc[r_rptr] + ADDR_W'(4);
    assign o_fifo_count    = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit (main 32-bit instance plus an 8-bit wrap instance)
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_imem_req, o_inst_valid;
    logic [31:0] o_imem_addr, o_inst, o_inst_pc, o_inst_pc_plus4;
    logic        i_imem_ack = 1'b0, i_redirect = 1'b0, i_inst_ready = 1'b0;
    logic [31:0] i_imem_data = '0, i_redirect_addr = '0;
    logic [2:0]  o_fifo_count;

    logic        o2_req, o2_valid;
    logic [7:0]  o2_addr, o2_pc, o2_pc4;
    logic [31:0] o2_inst;
    logic [1:0]  o2_count;
    logic        i2_ack = 1'b0, i2_ready = 1'b0;
    logic [31:0] i2_data = '0;

    int          n_total = 0, n_bad = 0;
    logic [63:0] q[$];
    logic [31:0] exp_pc = '0, stale_addr = '0;
    logic        stale = 1'b0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
        .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .o_inst_pc_plus4(o_inst_pc_plus4), .i_inst_ready(i_inst_ready),
        .o_fifo_count(o_fifo_count)
    );

    fetch_unit #(.ADDR_W(8), .DEPTH(2), .RESET_PC(8'hF8)) dut_w (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(o2_req), .o_imem_addr(o2_addr),
        .i_imem_ack(i2_ack), .i_imem_data(i2_data),
        .i_redirect(1'b0), .i_redirect_addr(8'h00),
        .o_inst_valid(o2_valid), .o_inst(o2_inst), .o_inst_pc(o2_pc),
        .o_inst_pc_plus4(o2_pc4), .i_inst_ready(i2_ready),
        .o_fifo_count(o2_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called at a falling edge: checks outputs, drives inputs, updates the model, advances one cycle
    task automatic step(input logic ack, input logic rdy, input logic redir, input logic [31:0] raddr);
        logic [63:0] e;
        logic [31:0] epc4;
        i_imem_ack      = ack;
        i_inst_ready    = rdy;
        i_redirect      = redir;
        i_redirect_addr = raddr;
        i_imem_data     = mem_word(o_imem_addr);
        chk("count", 64'(o_fifo_count), 64'(q.size()));
        chk("valid", 64'(o_inst_valid), 64'(q.size() != 0));
        if (o_imem_req)
            chk("addr", 64'(o_imem_addr), 64'(stale ? stale_addr : exp_pc));
        if (o_inst_valid && rdy && !redir && q.size() > 0) begin
            e    = q.pop_front();
            epc4 = e[31:0] + 32'd4;
            chk("inst", 64'(o_inst), 64'(e[63:32]));
            chk("inst_pc", 64'(o_inst_pc), 64'(e[31:0]));
            chk("inst_pc4", 64'(o_inst_pc_plus4), 64'(epc4));
        end
        if (o_imem_req && ack) begin
            if (stale)
                stale = 1'b0;
            else if (!redir) begin
                q.push_back({mem_word(exp_pc), exp_pc});
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (redir) begin
            q.delete();
            if (o_imem_req && !ack && !stale) begin
                stale      = 1'b1;
                stale_addr = o_imem_addr;
            end
            exp_pc = raddr & ~32'd3;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a, pa;
        logic       ack, rdy, redir;
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(o_imem_req), 64'(0));
        chk("rst_valid", 64'(o_inst_valid), 64'(0));
        chk("rst_count", 64'(o_fifo_count), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", 64'(o_imem_req), 64'(1));
        chk("first_addr", 64'(o_imem_addr), 64'(0));

        for (int k = 0; k < 12; k++) begin
            chk("s_req", 64'(o_imem_req), 64'(1));
            step(1'b1, 1'b1, 1'b0, '0);
        end

        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, '0);
        chk("bp_count", 64'(o_fifo_count), 64'(4));
        chk("bp_req", 64'(o_imem_req), 64'(0));
        step(1'b0, 1'b1, 1'b0, '0);
        chk("bp_req_idle", 64'(o_imem_req), 64'(0));
        step(1'b0, 1'b0, 1'b0, '0);
        chk("bp_req_rise", 64'(o_imem_req), 64'(1));
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, '0);

        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 32'h40);
        chk("rd_drop_valid", 64'(o_inst_valid), 64'(0));
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("rd_drop_addr", 64'(o_imem_addr), 64'(32'h40));
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, '0);

        step(1'b1, 1'b0, 1'b1, 32'h101);
        chk("rd_ack_addr", 64'(o_imem_addr), 64'(32'h100));
        chk("rd_ack_count", 64'(o_fifo_count), 64'(0));
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, '0);

        for (int k = 0; k < 300; k++) begin
            ack   = ($urandom_range(0, 99) < 60);
            rdy   = ($urandom_range(0, 99) < 60);
            redir = ($urandom_range(0, 99) < 5);
            if (redir && stale) ack = 1'b0;
            step(ack, rdy, redir, 32'($urandom_range(0, 1023)));
        end

        step(1'b0, 1'b0, 1'b1, 32'h200);
        for (int k = 0; k < 20 && q.size() < 3; k++) step(1'b1, 1'b0, 1'b0, '0);
        chk("pre_rst_count", 64'(o_fifo_count), 64'(3));
        chk("pre_rst_req", 64'(o_imem_req), 64'(1));
        i_imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(o_inst_valid), 64'(0));
        chk("arst_req", 64'(o_imem_req), 64'(0));
        chk("arst_count", 64'(o_fifo_count), 64'(0));
        q.delete();
        exp_pc = '0;
        stale  = 1'b0;
        @(negedge clk);
        rst          = 1'b0;
        i_redirect   = 1'b0;
        i_inst_ready = 1'b0;
        @(negedge clk);
        chk("rst2_req", 64'(o_imem_req), 64'(1));
        chk("rst2_addr", 64'(o_imem_addr), 64'(0));
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, '0);

        i2_ack   = 1'b1;
        i2_ready = 1'b1;
        a        = 8'hF8;
        for (int k = 0; k < 5; k++) begin
            i2_data = mem_word({24'h0, o2_addr});
            pa      = a - 8'd4;
            chk("w_addr", 64'(o2_addr), 64'(a));
            if (k > 0) begin
                chk("w_valid", 64'(o2_valid), 64'(1));
                chk("w_pc", 64'(o2_pc), 64'(pa));
                chk("w_pc4", 64'(o2_pc4), 64'(a));
                chk("w_inst", 64'(o2_inst), 64'(mem_word({24'h0, pa})));
            end
            a = a + 8'd4;
            @(negedge clk);
        end
        i2_ack   = 1'b0;
        i2_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
